axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- AXI4-Lite initiator bridging the RISC-V core / NN-accelerator load-store request port onto the AXI4-Lite memory bus.
- Issues one transaction at a time: single-beat write on the AW/W/B channels, single-beat read on the AR/R channels.
- Returns read data and an error flag to the requester.
- Drives the memory-side AXI4-Lite slave directly; signal names mirror that slave's port list.

Parameters:
- ADDR_WIDTH, 32, request/AXI address width
- DATA_WIDTH, 32, request/AXI data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with AXI_TIMEOUT_EN

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_address  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_error  out  1  1 = nonzero bus response or timeout
- write_address  out  ADDR_WIDTH  AW address
- write_valid  out  1  AW valid
- write_ready  in  1  AW ready
- write_data  out  DATA_WIDTH  W data
- write_data_valid  out  1  W valid
- write_data_ready  in  1  W ready
- write_response  in  32  B response; 0 = OKAY
- write_response_valid  in  1  B valid
- write_response_ready  out  1  B ready
- read_address  out  ADDR_WIDTH  AR address
- read_valid  out  1  AR valid
- read_ready  in  1  AR ready
- read_data  in  DATA_WIDTH  R data
- read_response  in  32  R response; 0 = OKAY
- read_response_valid  in  1  R valid
- read_response_ready  out  1  R ready

Behaviour:
- All outputs registered. Reset values:
  - req_ready = 1
  - all other outputs = 0
  - state = IDLE, done flags cleared
- States: IDLE, WRITE, READ, RESP.
- IDLE: req_ready = 1. On accept, latch address/data.
  - Write: next state WRITE, with write_valid, write_data_valid and write_response_ready all 1.
  - Read: next state READ, with read_valid and read_response_ready both 1.
  - AXI valids first appear the cycle after accept.
  - req_ready = 0 outside IDLE.
- AXI valid rule:
  - Each valid holds, with address/data stable, until its handshake (valid && ready sampled high).
  - Each valid drops the cycle after its handshake.
  - No valid ever depends combinationally on a ready.
- WRITE:
  - AW and W are independent; track aw_done and w_done; either order or same cycle is legal.
  - write_response_ready stays 1 from WRITE entry until the B handshake. A B beat is accepted whenever it arrives, even before aw_done.
  - On B: latch err = (write_response != 0).
  - Go to RESP when aw_done, w_done and b_done are all set. That includes the same cycle the last flag is set.
- READ:
  - read_response_ready stays 1 from READ entry until the R handshake.
  - On R: latch rsp_rdata = read_data and err = (read_response != 0).
  - Go to RESP when ar_done and r_done are both set.
- RESP:
  - rsp_valid = 1 with rsp_rdata and rsp_error stable.
  - On rsp_ready: rsp_valid = 0, clear done flags, return to IDLE (req_ready = 1 next cycle).
- Minimum latency is 4 cycles from accept to rsp_valid against a slave that raises ready the cycle after valid and returns its response one cycle after that.
- Unexpected B or R beats in IDLE/RESP: ready is 0, so they are ignored.
- Reset mid-transaction: outputs return to reset values immediately; the transaction is abandoned with no response.

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WRITE/READ and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES, drop all AXI valids/readys and go to RESP with rsp_error = 1, rsp_rdata = 0.
- Undefined:
  - No counter; the block waits indefinitely for handshakes.

Test Plan:
- Write 0xDEADBEEF to 0x10, slave ready 1 cycle after valid, B resp 0 -> one AW and one W handshake with write_address = 0x10, rsp_valid with rsp_error = 0.
- Read 0x10 after that write -> read_address = 0x10, rsp_rdata = 0xDEADBEEF, rsp_error = 0, latency 4 cycles.
- write_data_ready 3 cycles before write_ready, B arriving before AW handshake -> single response, no duplicate handshakes, rsp_error = 0.
- read_response = 2 -> rsp_error = 1, rsp_rdata = read_data; rsp_ready held 0 for 5 cycles -> rsp_valid and data held stable, req_ready = 0 throughout.
- Reset asserted during WRITE after AW handshake -> all outputs 0 and req_ready = 1 immediately; a new read then completes normally.
- With AXI_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never raises read_ready -> rsp_valid with rsp_error = 1, rsp_rdata = 0, 16 cycles after READ entry.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one single-beat read or write in flight; optional watchdog under `AXI_TIMEOUT_EN`.
// Latency: 4 cycles from accept to rsp_valid against a 1-cycle-ready / 1-cycle-response slave.
// Backpressure: req_ready is low until the response is taken; AXI valids hold until handshake.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  write_valid,
  input  logic                  write_ready,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_data_valid,
  input  logic                  write_data_ready,
  input  logic [31:0]           write_response,
  input  logic                  write_response_valid,
  output logic                  write_response_ready,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  read_valid,
  input  logic                  read_ready,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic [31:0]           read_response,
  input  logic                  read_response_valid,
  output logic                  read_response_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t state, state_nxt;
  logic aw_done, w_done, b_done, ar_done, r_done;
  logic aw_done_nxt, w_done_nxt, b_done_nxt, ar_done_nxt, r_done_nxt;
  logic req_ready_nxt, rsp_valid_nxt, rsp_error_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic write_valid_nxt, write_data_valid_nxt, write_response_ready_nxt;
  logic read_valid_nxt, read_response_ready_nxt;
  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;

  assign accept = req_valid && req_ready;
  assign aw_hs  = write_valid && write_ready;
  assign w_hs   = write_data_valid && write_data_ready;
  assign b_hs   = write_response_valid && write_response_ready;
  assign ar_hs  = read_valid && read_ready;
  assign r_hs   = read_response_valid && read_response_ready;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;

  // Held at zero outside WRITE/READ, so it starts from zero on every entry.
  assign to_cnt_nxt = ((state == WRITE) || (state == READ)) ? to_cnt + 1'b1 : '0;
  assign timeout    = ((state == WRITE) || (state == READ)) && (to_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) to_cnt <= '0;
    else       to_cnt <= to_cnt_nxt;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt                = state;
    aw_done_nxt              = aw_done;
    w_done_nxt               = w_done;
    b_done_nxt               = b_done;
    ar_done_nxt              = ar_done;
    r_done_nxt               = r_done;
    req_ready_nxt            = req_ready;
    rsp_valid_nxt            = rsp_valid;
    rsp_error_nxt            = rsp_error;
    rsp_rdata_nxt            = rsp_rdata;
    write_valid_nxt          = write_valid;
    write_data_valid_nxt     = write_data_valid;
    write_response_ready_nxt = write_response_ready;
    read_valid_nxt           = read_valid;
    read_response_ready_nxt  = read_response_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready_nxt = 1'b0;
          rsp_error_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          if (req_write) begin
            state_nxt                = WRITE;
            write_valid_nxt          = 1'b1;
            write_data_valid_nxt     = 1'b1;
            write_response_ready_nxt = 1'b1;
          end else begin
            state_nxt               = READ;
            read_valid_nxt          = 1'b1;
            read_response_ready_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_hs) begin
          write_valid_nxt = 1'b0;
          aw_done_nxt     = 1'b1;
        end
        if (w_hs) begin
          write_data_valid_nxt = 1'b0;
          w_done_nxt           = 1'b1;
        end
        // B is taken whenever it shows up, even ahead of the AW handshake.
        if (b_hs) begin
          write_response_ready_nxt = 1'b0;
          b_done_nxt               = 1'b1;
          rsp_error_nxt            = (write_response != 32'd0);
        end
        if (aw_done_nxt && w_done_nxt && b_done_nxt) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
        end
      end
      READ: begin
        if (ar_hs) begin
          read_valid_nxt = 1'b0;
          ar_done_nxt    = 1'b1;
        end
        if (r_hs) begin
          read_response_ready_nxt = 1'b0;
          r_done_nxt              = 1'b1;
          rsp_rdata_nxt           = read_data;
          rsp_error_nxt           = (read_response != 32'd0);
        end
        if (ar_done_nxt && r_done_nxt) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          aw_done_nxt   = 1'b0;
          w_done_nxt    = 1'b0;
          b_done_nxt    = 1'b0;
          ar_done_nxt   = 1'b0;
          r_done_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Watchdog expiry abandons the bus side and reports an error response.
    if (timeout && (state_nxt != RESP)) begin
      state_nxt                = RESP;
      rsp_valid_nxt            = 1'b1;
      rsp_error_nxt            = 1'b1;
      rsp_rdata_nxt            = '0;
      write_valid_nxt          = 1'b0;
      write_data_valid_nxt     = 1'b0;
      write_response_ready_nxt = 1'b0;
      read_valid_nxt           = 1'b0;
      read_response_ready_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      aw_done              <= 1'b0;
      w_done               <= 1'b0;
      b_done               <= 1'b0;
      ar_done              <= 1'b0;
      r_done               <= 1'b0;
      req_ready            <= 1'b1;
      rsp_valid            <= 1'b0;
      rsp_error            <= 1'b0;
      rsp_rdata            <= '0;
      write_valid          <= 1'b0;
      write_data_valid     <= 1'b0;
      write_response_ready <= 1'b0;
      read_valid           <= 1'b0;
      read_response_ready  <= 1'b0;
    end else begin
      state                <= state_nxt;
      aw_done              <= aw_done_nxt;
      w_done               <= w_done_nxt;
      b_done               <= b_done_nxt;
      ar_done              <= ar_done_nxt;
      r_done               <= r_done_nxt;
      req_ready            <= req_ready_nxt;
      rsp_valid            <= rsp_valid_nxt;
      rsp_error            <= rsp_error_nxt;
      rsp_rdata            <= rsp_rdata_nxt;
      write_valid          <= write_valid_nxt;
      write_data_valid     <= write_data_valid_nxt;
      write_response_ready <= write_response_ready_nxt;
      read_valid           <= read_valid_nxt;
      read_response_ready  <= read_response_ready_nxt;
    end
  end

  // Address/data captured on accept and held stable for the whole transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_address <= '0;
      write_data    <= '0;
      read_address  <= '0;
    end else if (accept) begin
      if (req_write) begin
        write_address <= req_address;
        write_data    <= req_wdata;
      end else begin
        read_address <= req_address;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: scripted AXI slave, expected responses queued at issue
// and checked by an independent response monitor.
module tb_axi_lite_master;

  localparam int TO = 16;

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_address, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] write_address, write_data, read_address, read_data;
  logic        write_valid, write_ready, write_data_valid, write_data_ready;
  logic [31:0] write_response, read_response;
  logic        write_response_valid, write_response_ready;
  logic        read_valid, read_ready, read_response_valid, read_response_ready;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .write_address(write_address), .write_valid(write_valid), .write_ready(write_ready),
    .write_data(write_data), .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_response(write_response), .write_response_valid(write_response_valid),
    .write_response_ready(write_response_ready),
    .read_address(read_address), .read_valid(read_valid), .read_ready(read_ready),
    .read_data(read_data), .read_response(read_response),
    .read_response_valid(read_response_valid), .read_response_ready(read_response_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] mem [logic [31:0]];

  // Slave knobs
  int aw_lat = 1, w_lat = 1, ar_lat = 1;
  bit b_early = 0, ar_never = 0;
  logic [31:0] bresp = 0, rresp = 0;

  // Slave observations
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_hs_cyc = 0, b_hs_cyc = 0;
  logic [31:0] last_aw_addr = 0, last_w_data = 0, last_ar_addr = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({nm, "_outputs_zero"},
        64'(|{rsp_valid, rsp_rdata, rsp_error, write_address, write_valid, write_data,
              write_data_valid, write_response_ready, read_address, read_valid,
              read_response_ready}), 64'd0);
  endtask

  // Write-side slave: AW, W and B in one process so their ordering is deterministic.
  initial begin : wr_slave
    int  aw_cnt, w_cnt;
    bit  aw_d, w_d, b_d, b_rdy_prev;
    write_ready = 0; write_data_ready = 0; write_response_valid = 0; write_response = 0;
    aw_cnt = 0; w_cnt = 0; aw_d = 0; w_d = 0; b_d = 0; b_rdy_prev = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        write_ready = 0; write_data_ready = 0; write_response_valid = 0;
        aw_cnt = 0; w_cnt = 0; aw_d = 0; w_d = 0; b_d = 0; b_rdy_prev = 0;
      end else begin
        if (write_ready) begin
          write_ready = 0; aw_cnt = 0; aw_d = 1; aw_hs_n++; aw_hs_cyc = cyc;
          chk("aw_valid_drop", 64'(write_valid), 64'd0);
        end else if (write_valid) begin
          if (aw_cnt >= aw_lat) begin write_ready = 1; last_aw_addr = write_address; end
          else aw_cnt++;
        end
        if (write_data_ready) begin
          write_data_ready = 0; w_cnt = 0; w_d = 1; w_hs_n++;
          chk("w_valid_drop", 64'(write_data_valid), 64'd0);
        end else if (write_data_valid) begin
          if (w_cnt >= w_lat) begin write_data_ready = 1; last_w_data = write_data; end
          else w_cnt++;
        end
        if (write_response_valid) begin
          if (b_rdy_prev) begin
            write_response_valid = 0; b_d = 1; b_hs_n++; b_hs_cyc = cyc;
            chk("b_ready_drop", 64'(write_response_ready), 64'd0);
          end
        end else if (!b_d && (b_early ? write_response_ready : (aw_d && w_d))) begin
          write_response_valid = 1; write_response = bresp;
        end
        if (aw_d && w_d && b_d) begin
          mem[last_aw_addr] = last_w_data;
          aw_d = 0; w_d = 0; b_d = 0;
        end
        b_rdy_prev = write_response_ready;
      end
    end
  end

  initial begin : rd_slave
    int ar_cnt;
    bit r_rdy_prev;
    read_ready = 0; read_response_valid = 0; read_data = 0; read_response = 0;
    ar_cnt = 0; r_rdy_prev = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        read_ready = 0; read_response_valid = 0; ar_cnt = 0; r_rdy_prev = 0;
      end else begin
        if (read_response_valid && r_rdy_prev) begin
          read_response_valid = 0; r_hs_n++;
          chk("r_ready_drop", 64'(read_response_ready), 64'd0);
        end
        if (read_ready) begin
          read_ready = 0; ar_cnt = 0; ar_hs_n++;
          chk("ar_valid_drop", 64'(read_valid), 64'd0);
          read_response_valid = 1;
          read_data = mem.exists(last_ar_addr) ? mem[last_ar_addr] : 32'd0;
          read_response = rresp;
        end else if (read_valid && !ar_never) begin
          if (ar_cnt >= ar_lat) begin read_ready = 1; last_ar_addr = read_address; end
          else ar_cnt++;
        end
        r_rdy_prev = read_response_ready;
      end
    end
  end

  // Response monitor: latency on first rsp_valid, data/error on handshake.
  initial begin : monitor
    bit   seen;
    exp_t it;
    seen = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) seen = 0;
      else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          if (!seen && sb[0].lat != 0) chk("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1;
          if (rsp_ready) begin
            it = sb.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(it.rdata));
            chk("rsp_error", 64'(rsp_error), 64'(it.err));
            seen = 0;
          end
        end
      end
    end
  end

  // Present one request; the accept cycle is the one whose closing edge samples valid && ready.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit push,
                       input logic [31:0] er, input bit ee, input int el);
    int   k;
    exp_t it;
    @(negedge clock);
    req_valid = 1; req_write = wr; req_address = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    if (!req_ready) begin
      chk("req_accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 0;
      return;
    end
    it.rdata = er; it.err = ee; it.lat = el; it.acc = cyc;
    @(posedge clock);
    #1;
    if (push) sb.push_back(it);
    @(negedge clock);
    req_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !rsp_valid) return;
    end
    chk("wait_idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : stim
    int k;
    int base;
    reset = 1; req_valid = 0; req_write = 0; req_address = 0; req_wdata = 0; rsp_ready = 1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 0;

    // 1: write 0xDEADBEEF to 0x10, 1-cycle ready, OKAY
    issue(1, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 4);
    wait_idle();
    chk("t1_aw_addr", 64'(last_aw_addr), 64'h10);
    chk("t1_w_data", 64'(last_w_data), 64'hDEADBEEF);
    chk("t1_aw_count", 64'(aw_hs_n), 64'd1);
    chk("t1_w_count", 64'(w_hs_n), 64'd1);
    chk("t1_b_count", 64'(b_hs_n), 64'd1);

    // 2: read it back, 4-cycle latency
    issue(0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 4);
    wait_idle();
    chk("t2_ar_addr", 64'(last_ar_addr), 64'h10);
    chk("t2_ar_count", 64'(ar_hs_n), 64'd1);

    // 3: W three cycles ahead of AW, B before the AW handshake
    aw_lat = 4; w_lat = 1; b_early = 1;
    issue(1, 32'h14, 32'hCAFEF00D, 1, 32'h0, 0, 0);
    wait_idle();
    chk("t3_b_before_aw", 64'(b_hs_cyc < aw_hs_cyc), 64'd1);
    chk("t3_aw_count", 64'(aw_hs_n), 64'd2);
    chk("t3_w_count", 64'(w_hs_n), 64'd2);
    chk("t3_b_count", 64'(b_hs_n), 64'd2);
    chk("t3_aw_addr", 64'(last_aw_addr), 64'h14);
    aw_lat = 1; b_early = 0;

    // 4: SLVERR read, response held off for 5 cycles
    rresp = 2; rsp_ready = 0;
    issue(0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1, 4);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clock); k++; end
    chk("t4_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      chk("t4_hold_error", 64'(rsp_error), 64'd1);
      chk("t4_hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1; rresp = 0;
    wait_idle();

    // 5: reset while W is still pending after the AW handshake
    w_lat = 20;
    base = aw_hs_n;
    issue(1, 32'h20, 32'h12345678, 0, 32'h0, 0, 0);
    k = 0;
    while (aw_hs_n == base && k < 50) begin @(negedge clock); #1; k++; end
    chk("t5_aw_done", 64'(aw_hs_n), 64'(base + 1));
    reset = 1;
    #1;
    check_reset_outputs("t5_midreset");
    repeat (2) @(negedge clock);
    reset = 0; w_lat = 1;
    issue(0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 4);
    wait_idle();
    chk("t5_ar_addr", 64'(last_ar_addr), 64'h10);

`ifdef AXI_TIMEOUT_EN
    // 6: AR never accepted; rsp_valid TO cycles after READ entry (READ entry = accept cycle + 1)
    ar_never = 1;
    issue(0, 32'h10, 32'h0, 1, 32'h0, 1, TO + 1);
    wait_idle();
    chk("t6_read_valid_dropped", 64'(read_valid), 64'd0);
    ar_never = 0;
`endif

    repeat (3) @(negedge clock);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
